// File: rtl/slot_alloc_pkg.sv
// Shared definitions for the slot allocator: FSM state encoding and the default pool size.
package slot_alloc_pkg;

  localparam int unsigned DEFAULT_NUM_SLOTS = 16;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/slot_allocator_chk.sv
// Property checker for slot_allocator: occupancy counter agrees with the free bitmap,
// and no allocation is ever accepted while the pool is full.
module slot_allocator_chk #(
  parameter int unsigned NUM_SLOTS = 16,
  parameter int unsigned CNT_W     = $clog2(NUM_SLOTS + 1)
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  input logic [NUM_SLOTS-1:0] bitmap,
  input logic [CNT_W-1:0]     used_cnt,
  input logic                 full,
  input logic                 alloc_fire
);

  a_cnt_matches_bitmap: assert property (@(posedge clk_i) disable iff (!rst_ni)
    int'(used_cnt) == int'(NUM_SLOTS) - $countones(bitmap));

  a_no_alloc_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(alloc_fire && full));

endmodule

// File: rtl/slot_allocator_lzc.sv
// Leading/trailing zero counter. MODE=0 counts trailing zeros (index of lowest set bit),
// MODE=1 counts leading zeros. cnt_o is 0 when the input is all zeros; empty_o flags that case.
module lzc #(
  parameter int unsigned WIDTH     = 2,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  if (MODE == 1'b0) begin : g_trailing
    // Scan from the top down so the lowest set bit is the last one to win.
    always_comb begin
      cnt_o = '0;
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        cnt_o = in_i[i] ? CNT_WIDTH'(i) : cnt_o;
      end
    end
  end else begin : g_leading
    // Scan from the bottom up so the highest set bit is the last one to win.
    always_comb begin
      cnt_o = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_o = in_i[i] ? CNT_WIDTH'(int'(WIDTH) - 1 - i) : cnt_o;
      end
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/slot_allocator.sv
// Free-list allocator: offers the lowest free slot over valid/ready, accepts returns on a
// separate port, detects illegal frees and supports a one-cycle global flush.
module slot_allocator
  import slot_alloc_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = DEFAULT_NUM_SLOTS,
  parameter int unsigned IDX_W     = $clog2(NUM_SLOTS),
  parameter int unsigned CNT_W     = $clog2(NUM_SLOTS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             alloc_valid_o,
  input  logic             alloc_ready_i,
  output logic [IDX_W-1:0] alloc_idx_o,
  input  logic             free_valid_i,
  input  logic [IDX_W-1:0] free_idx_i,
  output logic             free_ready_o,
  input  logic             flush_i,
  output logic             flush_done_o,
  output logic [CNT_W-1:0] used_cnt_o,
  output logic             full_o,
  output logic             err_o
);

  state_e               state_r;
  state_e               state_nxt_s;
  logic [NUM_SLOTS-1:0] bitmap_r;
  logic [NUM_SLOTS-1:0] bitmap_nxt_s;
  logic [CNT_W-1:0]     used_cnt_r;
  logic [CNT_W-1:0]     used_cnt_nxt_s;
  logic                 err_r;
  logic                 err_nxt_s;
  logic                 flush_done_r;

  logic [IDX_W-1:0]     lzc_cnt_s;
  logic                 lzc_empty_s;
  logic                 run_s;
  logic                 alloc_fire_s;
  logic                 free_fire_s;
  logic                 free_in_range_s;
  logic                 free_legal_s;
  logic [NUM_SLOTS-1:0] alloc_mask_s;
  logic [NUM_SLOTS-1:0] free_mask_s;

  lzc #(
    .WIDTH    (NUM_SLOTS),
    .MODE     (1'b0),
    .CNT_WIDTH(IDX_W)
  ) u_lzc (
    .in_i   (bitmap_r),
    .cnt_o  (lzc_cnt_s),
    .empty_o(lzc_empty_s)
  );

  assign run_s         = (state_r == ST_RUN);
  assign alloc_valid_o = run_s && !lzc_empty_s && !flush_i;
  assign alloc_idx_o   = lzc_cnt_s;
  assign free_ready_o  = run_s && !flush_i;
  assign full_o        = lzc_empty_s;
  assign used_cnt_o    = used_cnt_r;
  assign err_o         = err_r;
  assign flush_done_o  = flush_done_r;

  assign alloc_fire_s    = alloc_valid_o && alloc_ready_i;
  assign free_fire_s     = free_valid_i && free_ready_o;
  assign alloc_mask_s    = NUM_SLOTS'(1'b1) << alloc_idx_o;
  assign free_mask_s     = NUM_SLOTS'(1'b1) << free_idx_i;
  // Out-of-range indices shift the mask to zero, so the range test must stand on its own.
  assign free_in_range_s = ({1'b0, free_idx_i} < (IDX_W + 1)'(NUM_SLOTS));
  assign free_legal_s    = free_fire_s && free_in_range_s && ((bitmap_r & free_mask_s) == '0);

  // Next-state logic of the INIT/RUN/FLUSH controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT:  state_nxt_s = ST_RUN;
      ST_RUN:   state_nxt_s = flush_i ? ST_FLUSH : ST_RUN;
      ST_FLUSH: state_nxt_s = ST_RUN;
      default:  state_nxt_s = ST_INIT;
    endcase
  end

  // Next bitmap, occupancy and error; a freed bit tested against the pre-alloc bitmap
  // makes freeing the slot being allocated in the same cycle a double free.
  always_comb begin
    bitmap_nxt_s   = bitmap_r;
    used_cnt_nxt_s = used_cnt_r;
    err_nxt_s      = 1'b0;
    if (state_r == ST_FLUSH) begin
      bitmap_nxt_s   = '1;
      used_cnt_nxt_s = '0;
    end else begin
      bitmap_nxt_s = (bitmap_r & ~(alloc_fire_s ? alloc_mask_s : '0))
                   | (free_legal_s ? free_mask_s : '0);
      err_nxt_s    = free_fire_s && !free_legal_s;
      case ({alloc_fire_s, free_legal_s})
        2'b10:   used_cnt_nxt_s = used_cnt_r + CNT_W'(1'b1);
        2'b01:   used_cnt_nxt_s = used_cnt_r - CNT_W'(1'b1);
        default: used_cnt_nxt_s = used_cnt_r;
      endcase
    end
  end

  // State, bitmap, counter and pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= ST_INIT;
      bitmap_r     <= '1;
      used_cnt_r   <= '0;
      err_r        <= 1'b0;
      flush_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      bitmap_r     <= bitmap_nxt_s;
      used_cnt_r   <= used_cnt_nxt_s;
      err_r        <= err_nxt_s;
      flush_done_r <= (state_r == ST_FLUSH);
    end
  end

endmodule

// File: tb/tb_slot_allocator.sv
// Self-checking bench for slot_allocator: set-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_slot_allocator;

  localparam int NS = 16;
  localparam int IW = 4;
  localparam int CW = 5;

  logic          clk;
  logic          rst_n;
  logic          alloc_valid;
  logic          alloc_ready;
  logic [IW-1:0] alloc_idx;
  logic          free_valid;
  logic [IW-1:0] free_idx;
  logic          free_ready;
  logic          flush;
  logic          flush_done;
  logic [CW-1:0] used_cnt;
  logic          full;
  logic          err;

  int vectors;
  int miscompares;

  slot_allocator #(.NUM_SLOTS(NS)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .alloc_valid_o(alloc_valid),
    .alloc_ready_i(alloc_ready),
    .alloc_idx_o  (alloc_idx),
    .free_valid_i (free_valid),
    .free_idx_i   (free_idx),
    .free_ready_o (free_ready),
    .flush_i      (flush),
    .flush_done_o (flush_done),
    .used_cnt_o   (used_cnt),
    .full_o       (full),
    .err_o        (err)
  );

  slot_allocator_chk #(.NUM_SLOTS(NS)) u_chk (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .bitmap    (dut.bitmap_r),
    .used_cnt  (used_cnt),
    .full      (full),
    .alloc_fire(alloc_valid && alloc_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: the set of free slots ----------------
  logic [NS-1:0] m_free;
  logic          m_init;
  logic          m_flush;
  logic          m_err;
  logic          m_done;
  logic          m_run;
  logic          e_valid;
  logic          e_fr;

  function automatic int lowest(input logic [NS-1:0] v);
    for (int i = 0; i < NS; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic bit legal_free(input logic [NS-1:0] v, input int idx);
    return (idx < NS) && !v[idx];
  endfunction

  function automatic logic [NS-1:0] model_next(input logic [NS-1:0] v, input bit do_alloc,
                                               input bit do_free, input int idx);
    logic [NS-1:0] n;
    n = v;
    if (do_alloc) n[lowest(v)] = 1'b0;
    if (do_free && legal_free(v, idx)) n[idx] = 1'b1;
    return n;
  endfunction

  assign m_run   = !m_init && !m_flush;
  assign e_valid = m_run && (m_free != '0) && !flush;
  assign e_fr    = m_run && !flush;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_free  <= '1;
      m_init  <= 1'b1;
      m_flush <= 1'b0;
      m_err   <= 1'b0;
      m_done  <= 1'b0;
    end else begin
      m_init  <= 1'b0;
      m_done  <= m_flush;
      m_flush <= m_run && flush;
      if (m_flush) begin
        m_free <= '1;
        m_err  <= 1'b0;
      end else begin
        m_free <= model_next(m_free, e_valid && alloc_ready, e_fr && free_valid, int'(free_idx));
        m_err  <= e_fr && free_valid && !legal_free(m_free, int'(free_idx));
      end
    end
  end

  always @(negedge clk) begin
    chk("alloc_valid", int'(alloc_valid), int'(e_valid));
    chk("free_ready", int'(free_ready), int'(e_fr));
    chk("full", int'(full), int'(m_free == '0));
    chk("used_cnt", int'(used_cnt), NS - $countones(m_free));
    chk("err", int'(err), int'(m_err));
    chk("flush_done", int'(flush_done), int'(m_done));
    if (m_free != '0) chk("alloc_idx", int'(alloc_idx), lowest(m_free));
  end

  // ---------------- directed stimulus ----------------
  logic [15:0] lfsr;
  int          free_list[6] = '{6, 7, 8, 10, 11, 12};

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    alloc_ready = 1'b0;
    free_valid  = 1'b0;
    free_idx    = '0;
    flush       = 1'b0;
    lfsr        = 16'hACE1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", int'(alloc_valid), 0);
    chk("rst_free_ready", int'(free_ready), 0);
    chk("rst_used", int'(used_cnt), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_idx", int'(alloc_idx), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_done", int'(flush_done), 0);

    // Fill the pool in order after the single INIT cycle.
    @(posedge clk); #1;
    rst_n       = 1'b1;
    alloc_ready = 1'b1;
    @(negedge clk);
    chk("init_no_offer", int'(alloc_valid), 0);
    for (int i = 0; i < NS; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("fill_valid", int'(alloc_valid), 1);
      chk("fill_idx", int'(alloc_idx), i);
    end
    @(posedge clk); #1;
    alloc_ready = 1'b0;
    @(negedge clk);
    chk("full_flag", int'(full), 1);
    chk("full_valid", int'(alloc_valid), 0);
    chk("full_used", int'(used_cnt), 16);

    // Return slot 9 from a full pool.
    @(posedge clk); #1;
    free_valid = 1'b1;
    free_idx   = 4'd9;
    @(negedge clk);
    chk("free9_ready", int'(free_ready), 1);
    @(posedge clk); #1;
    free_valid = 1'b0;
    @(negedge clk);
    chk("free9_valid", int'(alloc_valid), 1);
    chk("free9_idx", int'(alloc_idx), 9);
    chk("free9_used", int'(used_cnt), 15);
    chk("free9_full", int'(full), 0);

    // Free 2, then allocate 2 while freeing 0 in the same cycle.
    @(posedge clk); #1;
    free_valid = 1'b1;
    free_idx   = 4'd2;
    @(posedge clk); #1;
    free_valid = 1'b0;
    @(negedge clk);
    chk("free2_idx", int'(alloc_idx), 2);
    chk("free2_used", int'(used_cnt), 14);
    @(posedge clk); #1;
    alloc_ready = 1'b1;
    free_valid  = 1'b1;
    free_idx    = 4'd0;
    @(negedge clk);
    chk("both_valid", int'(alloc_valid), 1);
    chk("both_idx", int'(alloc_idx), 2);
    @(posedge clk); #1;
    alloc_ready = 1'b0;
    free_valid  = 1'b0;
    @(negedge clk);
    chk("both_used", int'(used_cnt), 14);
    chk("both_next_idx", int'(alloc_idx), 0);
    chk("both_err", int'(err), 0);

    // Free 5 legally, then again as a double free.
    @(posedge clk); #1;
    free_valid = 1'b1;
    free_idx   = 4'd5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    free_valid = 1'b0;
    @(negedge clk);
    chk("dbl_err", int'(err), 1);
    chk("dbl_used", int'(used_cnt), 13);
    @(posedge clk); #1;
    @(negedge clk);
    chk("dbl_err_clear", int'(err), 0);
    chk("dbl_used_after", int'(used_cnt), 13);
    chk("dbl_idx", int'(alloc_idx), 0);

    // Bring occupancy to 7, then flush for one cycle.
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      free_valid = 1'b1;
      free_idx   = IW'(free_list[k]);
    end
    @(posedge clk); #1;
    free_valid = 1'b0;
    @(negedge clk);
    chk("pre_flush_used", int'(used_cnt), 7);
    @(posedge clk); #1;
    flush       = 1'b1;
    alloc_ready = 1'b1;
    @(negedge clk);
    chk("flush_blocks_alloc", int'(alloc_valid), 0);
    chk("flush_blocks_free", int'(free_ready), 0);
    @(posedge clk); #1;
    flush       = 1'b0;
    alloc_ready = 1'b0;
    @(negedge clk);
    chk("flushing_valid", int'(alloc_valid), 0);
    chk("flushing_done", int'(flush_done), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush_done_pulse", int'(flush_done), 1);
    chk("flush_used", int'(used_cnt), 0);
    chk("flush_idx", int'(alloc_idx), 0);
    chk("flush_valid", int'(alloc_valid), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush_done_once", int'(flush_done), 0);

    // Pseudo-random traffic with a mid-run reset; the model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int s = 0; s < 5; s++) lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      alloc_ready = lfsr[0];
      free_valid  = lfsr[1] | lfsr[2];
      free_idx    = lfsr[7:4];
      flush       = (lfsr[15:10] == 6'd0);
      if (c == 1500) rst_n = 1'b0;
      if (c == 1503) rst_n = 1'b1;
    end

    @(posedge clk); #1;
    alloc_ready = 1'b0;
    free_valid  = 1'b0;
    flush       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
